// File: rtl/ym_bus_master_if.sv
// Request/response and PSG bus signals shared between the bus master and its client/PSG.
interface ym_bus_master_if;
  logic       REQ_VALID;
  logic       REQ_READY;
  logic       REQ_WR;
  logic [3:0] REQ_ADDR;
  logic [7:0] REQ_DATA;
  logic       RSP_VALID;
  logic [7:0] RSP_DATA;
  logic       BDIR;
  logic       BC;
  logic [7:0] BUS_DO;
  logic [7:0] BUS_DI;
  logic       BUSY;

  modport master (
    input  REQ_VALID, REQ_WR, REQ_ADDR, REQ_DATA, BUS_DI,
    output REQ_READY, RSP_VALID, RSP_DATA, BDIR, BC, BUS_DO, BUSY
  );

  modport slave (
    output REQ_VALID, REQ_WR, REQ_ADDR, REQ_DATA, BUS_DI,
    input  REQ_READY, RSP_VALID, RSP_DATA, BDIR, BC, BUS_DO, BUSY
  );
endinterface

// File: rtl/ym_bus_master.sv
// Queues PSG register read/write requests and sequences them onto the BDIR/BC bus,
// skipping the address phase when the PSG already has the target register latched.
module ym_bus_master #(
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned PHASE_CYC  = 2
) (
  input  logic CLK,
  input  logic RESET_N,
  input  logic CE,
  ym_bus_master_if.master bus
);
  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam logic [AW:0] DEPTH_C = (AW+1)'(FIFO_DEPTH);
  localparam logic [3:0]  PH_LOAD = 4'(PHASE_CYC - 1);

  typedef enum logic [2:0] {S_IDLE, S_ADDR, S_GAP_A, S_XFER_W, S_XFER_R, S_GAP_E} state_t;

  typedef struct packed {
    logic       wr;
    logic [3:0] addr;
    logic [7:0] data;
  } req_t;

  req_t          mem_q [FIFO_DEPTH];
  logic [AW-1:0] wptr_q, rptr_q;
  logic [AW:0]   cnt_q;
  state_t        state_q, state_d;
  logic [3:0]    phase_q, phase_d;
  req_t          cur_q, cur_d;
  logic          cache_v_q, cache_v_d;
  logic [3:0]    cache_a_q, cache_a_d;
  logic          rsp_valid_q, rsp_valid_d;
  logic [7:0]    rsp_data_q, rsp_data_d;
  logic          push, pop;
  req_t          head;
  logic          bdir, bc;
  logic [7:0]    bus_do;

  assign push = bus.REQ_VALID && (cnt_q != DEPTH_C);
  assign head = mem_q[rptr_q];

  always_ff @(posedge CLK) begin
    if (push) mem_q[wptr_q] <= '{wr: bus.REQ_WR, addr: bus.REQ_ADDR, data: bus.REQ_DATA};
  end

  always_comb begin
    state_d     = state_q;
    phase_d     = phase_q;
    cur_d       = cur_q;
    cache_v_d   = cache_v_q;
    cache_a_d   = cache_a_q;
    rsp_valid_d = 1'b0;
    rsp_data_d  = rsp_data_q;
    pop         = 1'b0;
    if (CE) begin
      if (state_q == S_IDLE) begin
        if (cnt_q != '0) begin
          pop     = 1'b1;
          cur_d   = head;
          phase_d = PH_LOAD;
          if (cache_v_q && (cache_a_q == head.addr)) state_d = head.wr ? S_XFER_W : S_XFER_R;
          else                                        state_d = S_ADDR;
        end
      end else if (phase_q != '0) begin
        phase_d = phase_q - 4'd1;
      end else begin
        phase_d = PH_LOAD;
        unique case (state_q)
          S_ADDR: begin
            state_d   = S_GAP_A;
            cache_v_d = 1'b1;
            cache_a_d = cur_q.addr;
          end
          S_GAP_A:  state_d = cur_q.wr ? S_XFER_W : S_XFER_R;
          S_XFER_W: state_d = S_GAP_E;
          S_XFER_R: begin
            state_d     = S_GAP_E;
            rsp_valid_d = 1'b1;
            rsp_data_d  = bus.BUS_DI;
          end
          default:  state_d = S_IDLE;
        endcase
      end
    end
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      wptr_q      <= '0;
      rptr_q      <= '0;
      cnt_q       <= '0;
      state_q     <= S_IDLE;
      phase_q     <= '0;
      cur_q       <= '0;
      cache_v_q   <= 1'b0;
      cache_a_q   <= '0;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
    end else begin
      if (push) wptr_q <= wptr_q + 1'b1;
      if (pop)  rptr_q <= rptr_q + 1'b1;
      case ({push, pop})
        2'b10:   cnt_q <= cnt_q + 1'b1;
        2'b01:   cnt_q <= cnt_q - 1'b1;
        default: cnt_q <= cnt_q;
      endcase
      state_q     <= state_d;
      phase_q     <= phase_d;
      cur_q       <= cur_d;
      cache_v_q   <= cache_v_d;
      cache_a_q   <= cache_a_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
    end
  end

  // Bus pins decode straight from the state register so reset clears them without a clock.
  always_comb begin
    bdir   = 1'b0;
    bc     = 1'b0;
    bus_do = '0;
    case (state_q)
      S_ADDR: begin
        bdir   = 1'b1;
        bc     = 1'b1;
        bus_do = {4'h0, cur_q.addr};
      end
      S_XFER_W: begin
        bdir   = 1'b1;
        bus_do = cur_q.data;
      end
      S_XFER_R: bc = 1'b1;
      default: ;
    endcase
  end

  assign bus.BDIR      = bdir;
  assign bus.BC        = bc;
  assign bus.BUS_DO    = bus_do;
  assign bus.REQ_READY = (cnt_q != DEPTH_C);
  assign bus.RSP_VALID = rsp_valid_q;
  assign bus.RSP_DATA  = rsp_data_q;
  assign bus.BUSY      = (cnt_q != '0) || (state_q != S_IDLE);
endmodule

// File: tb/tb_ym_bus_master.sv
// Scoreboard bench for ym_bus_master: a PSG model answers the bus, a request-level
// reference model predicts each bus transaction and read response.
module tb_ym_bus_master;
  localparam int PC    = 2;
  localparam int DEPTH = 4;

  logic CLK = 1'b0;
  logic RESET_N = 1'b0;
  logic CE = 1'b0;
  int   ce_mode = 0;
  int unsigned ce_div = 0;

  ym_bus_master_if bus ();

  ym_bus_master #(.FIFO_DEPTH(DEPTH), .PHASE_CYC(PC)) dut (
    .CLK(CLK), .RESET_N(RESET_N), .CE(CE), .bus(bus)
  );

  always #5 CLK = ~CLK;

  // CE pattern: 0 always on, 1 every 4th clock, 2 random, 3 held low
  always @(posedge CLK) begin
    #1;
    case (ce_mode)
      0:       CE = 1'b1;
      1:       CE = (ce_div % 4 == 0);
      2:       CE = 1'($urandom_range(0, 1));
      default: CE = 1'b0;
    endcase
    ce_div++;
  end

  // PSG model
  logic [7:0] psg_regs [16];
  logic [3:0] psg_latch = '0;
  assign bus.BUS_DI = psg_regs[psg_latch];
  always @(posedge CLK) begin
    if (CE && bus.BDIR && bus.BC)  psg_latch = bus.BUS_DO[3:0];
    if (CE && bus.BDIR && !bus.BC) psg_regs[psg_latch] = bus.BUS_DO;
  end

  int n_checks = 0;
  int n_pass   = 0;

  task automatic chk(string name, int act, int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  // Reference model: one entry per accepted request
  typedef struct {
    bit       wr;
    bit [3:0] addr;
    bit [7:0] data;
    bit       addr_ph;
  } txn_t;

  txn_t     exp_q [$];
  bit [7:0] rsp_q [$];
  bit [7:0] mregs [16];
  bit       mcache_v = 0;
  bit [3:0] mcache_a = '0;

  task automatic model_accept(bit wr, bit [3:0] a, bit [7:0] d);
    txn_t t;
    t.wr = wr; t.addr = a; t.data = d;
    t.addr_ph = !mcache_v || (mcache_a != a);
    mcache_v = 1; mcache_a = a;
    if (wr) mregs[a] = d;
    else    rsp_q.push_back(mregs[a]);
    exp_q.push_back(t);
  endtask

  task automatic push(bit wr, bit [3:0] a, bit [7:0] d);
    @(negedge CLK);
    bus.REQ_VALID = 1'b1; bus.REQ_WR = wr; bus.REQ_ADDR = a; bus.REQ_DATA = d;
    for (int i = 0; i < 2000; i++) begin
      if (bus.REQ_READY) begin
        @(posedge CLK);
        model_accept(wr, a, d);
        #1 bus.REQ_VALID = 1'b0;
        return;
      end
      @(negedge CLK);
    end
    chk("push_timeout", 0, 1);
    bus.REQ_VALID = 1'b0;
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 5000; i++) begin
      @(negedge CLK);
      if (!bus.BUSY && exp_q.size() == 0) break;
    end
    repeat (3) @(negedge CLK);
    chk("busy_after_idle", bus.BUSY, 0);
  endtask

  // Monitor: splits the bus into runs of constant {BDIR,BC,BUS_DO} and rebuilds transactions
  logic [1:0] cur_code = '0;
  logic [7:0] cur_do   = '0;
  int  run_ce = 0, run_clk = 0, run_mode = 0, gap_ce = 0;
  bit  pend_addr = 0, prev_rsp = 0;
  bit [3:0] last_addr = '0;
  bit [7:0] last_rsp  = '0;

  task automatic end_run();
    txn_t e;
    bit   timed;
    timed = (run_mode == 1) && (ce_mode == 1);
    case (cur_code)
      2'b11: begin
        chk("addr_phase_ce", run_ce, PC);
        chk("addr_do_hi", int'(cur_do[7:4]), 0);
        if (timed) chk("addr_phase_clk", run_clk, PC * 4);
        pend_addr = 1; last_addr = cur_do[3:0]; gap_ce = 0;
      end
      2'b00: if (pend_addr) gap_ce = run_ce;
      default: begin
        if (exp_q.size() == 0) chk("unexpected_xfer", 1, 0);
        else begin
          e = exp_q.pop_front();
          chk("xfer_dir_wr", int'(cur_code == 2'b10), int'(e.wr));
          chk("xfer_addr", int'(last_addr), int'(e.addr));
          chk("addr_phase_present", int'(pend_addr), int'(e.addr_ph));
          chk("xfer_do", int'(cur_do), e.wr ? int'(e.data) : 0);
          chk("xfer_phase_ce", run_ce, PC);
          if (pend_addr) chk("gap_a_ce", gap_ce, PC);
          if (timed) chk("xfer_phase_clk", run_clk, PC * 4);
        end
        pend_addr = 0;
      end
    endcase
  endtask

  always @(negedge CLK) begin
    if (!RESET_N) begin
      exp_q.delete(); rsp_q.delete();
      cur_code = '0; cur_do = '0; run_ce = 0; run_clk = 0;
      pend_addr = 0; gap_ce = 0; prev_rsp = 0;
    end else begin
      if ({bus.BDIR, bus.BC} != cur_code || bus.BUS_DO != cur_do) begin
        end_run();
        cur_code = {bus.BDIR, bus.BC}; cur_do = bus.BUS_DO;
        run_ce = int'(CE); run_clk = 1; run_mode = ce_mode;
      end else begin
        run_ce += int'(CE); run_clk++;
      end
      if (bus.RSP_VALID) begin
        if (rsp_q.size() == 0) chk("unexpected_rsp_valid", 1, 0);
        else chk("rsp_data", int'(bus.RSP_DATA), int'(rsp_q.pop_front()));
        chk("rsp_single_pulse", int'(prev_rsp), 0);
        last_rsp = bus.RSP_DATA;
      end else if (prev_rsp) begin
        chk("rsp_data_hold", int'(bus.RSP_DATA), int'(last_rsp));
      end
      prev_rsp = bus.RSP_VALID;
    end
  end

  initial begin
    bit found;
    bus.REQ_VALID = 1'b0; bus.REQ_WR = 1'b0; bus.REQ_ADDR = '0; bus.REQ_DATA = '0;
    for (int i = 0; i < 16; i++) begin
      psg_regs[i] = 8'($urandom);
      mregs[i] = psg_regs[i];
    end
    psg_regs[14] = 8'hA5; mregs[14] = 8'hA5;

    repeat (3) @(posedge CLK);
    #2;
    chk("rst_bdir", bus.BDIR, 0);
    chk("rst_bc", bus.BC, 0);
    chk("rst_bus_do", int'(bus.BUS_DO), 0);
    chk("rst_rsp_valid", bus.RSP_VALID, 0);
    chk("rst_rsp_data", int'(bus.RSP_DATA), 0);
    chk("rst_req_ready", bus.REQ_READY, 1);
    chk("rst_busy", bus.BUSY, 0);
    RESET_N = 1'b1;

    // Write reg 7 twice, then read reg 14 (PSG returns A5)
    push(1, 4'd7, 8'h3E);
    push(1, 4'd7, 8'h38);
    push(0, 4'd14, 8'h00);
    wait_idle();
    chk("rsp_data_held", int'(bus.RSP_DATA), 8'hA5);

    // Slow CE: every phase should stretch to 8 clocks
    ce_mode = 1;
    push(1, 4'd3, 8'h5A);
    push(0, 4'd3, 8'h00);
    push(1, 4'd13, 8'h09);
    wait_idle();

    // FIFO fill with CE frozen
    ce_mode = 3;
    repeat (4) @(negedge CLK);
    fork
      for (int i = 0; i < 5; i++) push(1, 4'(i), 8'(8'h10 + i));
      begin
        repeat (15) @(negedge CLK);
        chk("full_ready_low", bus.REQ_READY, 0);
        chk("full_busy", bus.BUSY, 1);
        chk("frozen_bdir", bus.BDIR, 0);
        ce_mode = 0;
      end
    join
    wait_idle();

    // Randomized traffic with random CE, narrow address set for cache hits
    ce_mode = 2;
    for (int n = 0; n < 40; n++) begin
      bit [3:0] a;
      case ($urandom_range(0, 3))
        0: a = 4'd13;
        1: a = 4'd14;
        default: a = 4'($urandom_range(0, 3));
      endcase
      push(1'($urandom_range(0, 1)), a, 8'($urandom));
      if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 20)) @(negedge CLK);
    end
    wait_idle();

    // Reset during XFER_W with queued requests
    ce_mode = 0;
    push(1, 4'd5, 8'hC3);
    push(1, 4'd5, 8'h11);
    push(0, 4'd5, 8'h00);
    found = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge CLK);
      if (bus.BDIR && !bus.BC) begin found = 1; break; end
    end
    chk("reached_xfer_w", int'(found), 1);
    @(posedge CLK);
    #1 RESET_N = 1'b0;
    #1;
    chk("rstmid_bdir", bus.BDIR, 0);
    chk("rstmid_bc", bus.BC, 0);
    chk("rstmid_bus_do", int'(bus.BUS_DO), 0);
    chk("rstmid_busy", bus.BUSY, 0);
    chk("rstmid_ready", bus.REQ_READY, 1);
    repeat (2) @(negedge CLK);
    mcache_v = 0;
    for (int i = 0; i < 16; i++) mregs[i] = psg_regs[i];
    RESET_N = 1'b1;
    repeat (4) @(negedge CLK);
    chk("post_rst_no_rsp", bus.RSP_VALID, 0);
    push(1, 4'd5, 8'h77);
    push(0, 4'd5, 8'h00);
    wait_idle();

    chk("exp_q_drained", exp_q.size(), 0);
    chk("rsp_q_drained", rsp_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end
endmodule

// File: doc/ym_bus_master.md
YM_BUS_MASTER -- requirements
Module: ym_bus_master

Interface
REQ-001 Parameters SHALL be: FIFO_DEPTH, default 4, request FIFO entries (power of two, 2..16); PHASE_CYC, default 2, CE pulses per bus phase (1..15).
REQ-002 CLK  in  1  global clock.
REQ-003 RESET_N  in  1  reset, asynchronous, active-low.
REQ-004 CE  in  1  bus-timing clock enable (PSG CE domain).
REQ-005 REQ_VALID  in  1  request offered.
REQ-006 REQ_READY  out  1  FIFO can accept a request.
REQ-007 REQ_WR  in  1  1 = register write, 0 = register read.
REQ-008 REQ_ADDR  in  4  PSG register number 0..15.
REQ-009 REQ_DATA  in  8  write data; ignored for reads.
REQ-010 RSP_VALID  out  1  one-clock pulse, read data available.
REQ-011 RSP_DATA  out  8  read result, held until next read completes.
REQ-012 BDIR  out  1  PSG bus direction.
REQ-013 BC  out  1  PSG bus control.
REQ-014 BUS_DO  out  8  data driven to PSG DI.
REQ-015 BUS_DI  in  8  data from PSG DO.
REQ-016 BUSY  out  1  FIFO non-empty or FSM not IDLE.

Function
REQ-017 Request accepted on any CLK edge with REQ_VALID & REQ_READY, independent of CE; REQ_READY SHALL be !full.
REQ-018 FIFO SHALL be first-in-first-out; pointers wrap modulo FIFO_DEPTH; simultaneous push and pop with FIFO non-full SHALL keep occupancy unchanged.
REQ-019 FSM states: IDLE, ADDR, GAP_A, XFER_W, XFER_R, GAP_E; transitions occur only on clock edges with CE=1.
REQ-020 Bus encoding per state: IDLE/GAP_A/GAP_E BDIR=0 BC=0; ADDR BDIR=1 BC=1 BUS_DO={4'h0,addr}; XFER_W BDIR=1 BC=0 BUS_DO=data; XFER_R BDIR=0 BC=1 BUS_DO=8'h00.
REQ-021 BUS_DO SHALL be 8'h00 in IDLE, GAP_A, GAP_E.
REQ-022 IDLE with CE and FIFO non-empty SHALL pop the head entry: if address cache valid and equal to entry addr, go to XFER_W/XFER_R; else go to ADDR.
REQ-023 ADDR, GAP_A, XFER_W, XFER_R, GAP_E SHALL each last exactly PHASE_CYC CE pulses (phase counter loaded PHASE_CYC-1 on entry, decremented on CE, exit on CE when zero).
REQ-024 Sequence: ADDR -> GAP_A -> XFER_W or XFER_R -> GAP_E -> IDLE.
REQ-025 Leaving ADDR SHALL load address cache with entry addr and set cache valid.
REQ-026 XFER_R SHALL sample BUS_DI into RSP_DATA on its final CE edge; RSP_VALID SHALL be 1 on the following clock only.
REQ-027 Writes SHALL never assert RSP_VALID.
REQ-028 A write to register 13 SHALL still follow the normal sequence; no extra gap.
REQ-029 Request fields SHALL be captured at pop; FIFO contents never alter an in-flight transaction.
REQ-030 CE held low SHALL freeze FSM, phase counter and bus outputs; FIFO still accepts pushes.

Reset
REQ-031 RESET_N=0 SHALL asynchronously force: FSM IDLE, FIFO empty, cache invalid, BDIR=0, BC=0, BUS_DO=8'h00, RSP_VALID=0, RSP_DATA=8'h00, REQ_READY=1, BUSY=0.
REQ-032 Reset mid-transaction SHALL abort it; in-flight and queued requests discarded, no RSP_VALID produced.
REQ-033 After RESET_N release, the first transaction SHALL always include an ADDR phase.

Verification
REQ-034 CE=1 always, PHASE_CYC=2: write reg 7 = 8'h3E -> BDIR/BC 11 for 2 clk with BUS_DO=8'h07, 00 for 2, 10 for 2 with BUS_DO=8'h3E, 00 for 2, BUSY low after.
REQ-035 Second write to reg 7 = 8'h38 immediately after -> no ADDR phase; 10 phase with BUS_DO=8'h38 starts the clock after IDLE pop.
REQ-036 Read reg 14 with BUS_DI=8'hA5 -> ADDR 8'h0E, GAP_A, XFER_R (BC=1 BDIR=0), RSP_DATA=8'hA5, one RSP_VALID pulse, RSP_DATA stays 8'hA5.
REQ-037 Push 5 writes back-to-back with FIFO_DEPTH=4 and CE held low -> REQ_READY low after 4th accept, 5th held until first pop; all 5 issued in order once CE resumes.
REQ-038 CE every 4th clock -> every phase lasts 8 clocks (PHASE_CYC=2); outputs stable between CE pulses.
REQ-039 Assert RESET_N=0 during XFER_W -> BDIR/BC 00 and BUS_DO 8'h00 immediately (before next CLK edge), BUSY=0; next request after release shows ADDR phase.
